// File: rtl/timer_array.sv
// timer_array: N_TIMERS independent memory-mapped down-counters behind one bus slave port.
//
// Each channel occupies 16 bytes at BASE_ADDR + 16*i:
//   +0x0 CTRL   [0] EN, [2:1] MODE (01 auto-reload, otherwise one-shot), [3] IM
//   +0x4 PRESET reload value (CNT_WIDTH bits, zero-extended on read)
//   +0x8 COUNT  current count, read-only
//   +0xC STATUS [0] PEND, sticky; write 1 to bit 0 (byte lane 0) to clear
//
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   addr             word address [31:2] from the CPU data port
//   we, byteen       write strobe (qualified by hit) and byte-lane enables
//   wdata, rdata     write data; combinational read data (0 when hit=0)
//   hit              address falls inside this peripheral's window
//   irq, irq_any     registered per-channel interrupts and their OR
module timer_array #(
   parameter int unsigned N_TIMERS  = 2,
   parameter int unsigned CNT_WIDTH = 32,
   parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [29:0]         addr,
   input  logic                we,
   input  logic [3:0]          byteen,
   input  logic [31:0]         wdata,
   output logic [31:0]         rdata,
   output logic                hit,
   output logic [N_TIMERS-1:0] irq,
   output logic                irq_any
);

   localparam logic [31:0] SpanBytes = 32'(16 * N_TIMERS);

   typedef enum logic [1:0] {StIdle, StLoad, StCnt, StInt} state_e;

   state_e               state_q  [N_TIMERS];
   logic [CNT_WIDTH-1:0] preset_q [N_TIMERS];
   logic [CNT_WIDTH-1:0] count_q  [N_TIMERS];
   logic [1:0]           mode_q   [N_TIMERS];
   logic [N_TIMERS-1:0]  en_q;
   logic [N_TIMERS-1:0]  im_q;
   logic [N_TIMERS-1:0]  pend_q;
   logic [N_TIMERS-1:0]  irq_q;

   logic [31:0]         offset;
   logic [2:0]          sel_ch;
   logic [1:0]          sel_word;
   logic [N_TIMERS-1:0] wr_ch;

   // Unsigned wrap makes addresses below BASE_ADDR land far outside the window.
   assign offset   = {addr, 2'b00} - BASE_ADDR;
   assign hit      = (offset < SpanBytes);
   assign sel_ch   = offset[6:4];
   assign sel_word = offset[3:2];

   always_comb begin
      wr_ch = '0;
      for (int i = 0; i < N_TIMERS; i++) begin
         wr_ch[i] = we && hit && (sel_ch == 3'(i));
      end
   end

   function automatic logic [31:0] lane_merge(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  be);
      logic [31:0] res;
      for (int b = 0; b < 4; b++) begin
         res[8*b +: 8] = be[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
      end
      return res;
   endfunction

   // Per-channel FSM and register file. Assignment order matters: the hardware
   // PEND set follows the W1C clear (set wins), and the CTRL bus write follows
   // the FSM clearing EN (bus write wins).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < N_TIMERS; i++) begin
            state_q[i]  <= StIdle;
            preset_q[i] <= '0;
            count_q[i]  <= '0;
            mode_q[i]   <= 2'b00;
         end
         en_q   <= '0;
         im_q   <= '0;
         pend_q <= '0;
         irq_q  <= '0;
      end else begin
         for (int i = 0; i < N_TIMERS; i++) begin
            // irq lags PEND by one cycle and follows IM one cycle after it changes.
            irq_q[i] <= pend_q[i] & im_q[i];

            if (wr_ch[i] && sel_word == 2'd3 && byteen[0] && wdata[0]) begin
               pend_q[i] <= 1'b0;
            end

            unique case (state_q[i])
               StIdle: begin
                  if (en_q[i]) state_q[i] <= StLoad;
               end
               StLoad: begin
                  count_q[i] <= preset_q[i];
                  state_q[i] <= StCnt;
               end
               StCnt: begin
                  if (!en_q[i]) begin
                     state_q[i] <= StIdle;
                  end else if (count_q[i] > CNT_WIDTH'(1)) begin
                     count_q[i] <= count_q[i] - CNT_WIDTH'(1);
                  end else begin
                     count_q[i] <= '0;
                     pend_q[i]  <= 1'b1;
                     state_q[i] <= StInt;
                  end
               end
               StInt: begin
                  // Auto-reload only while still enabled; a late EN=0 parks the channel.
                  if (mode_q[i] == 2'b01 && en_q[i]) begin
                     state_q[i] <= StLoad;
                  end else begin
                     en_q[i]    <= 1'b0;
                     state_q[i] <= StIdle;
                  end
               end
               default: state_q[i] <= StIdle;
            endcase

            if (wr_ch[i] && sel_word == 2'd0 && byteen[0]) begin
               en_q[i]   <= wdata[0];
               mode_q[i] <= wdata[2:1];
               im_q[i]   <= wdata[3];
            end

            if (wr_ch[i] && sel_word == 2'd1) begin
               preset_q[i] <= CNT_WIDTH'(lane_merge(32'(preset_q[i]), wdata, byteen));
            end
         end
      end
   end

   always_comb begin
      rdata = '0;
      if (hit) begin
         for (int i = 0; i < N_TIMERS; i++) begin
            if (sel_ch == 3'(i)) begin
               case (sel_word)
                  2'd0:    rdata = {28'd0, im_q[i], mode_q[i], en_q[i]};
                  2'd1:    rdata = 32'(preset_q[i]);
                  2'd2:    rdata = 32'(count_q[i]);
                  default: rdata = {31'd0, pend_q[i]};
               endcase
            end
         end
      end
   end

   assign irq     = irq_q;
   assign irq_any = |irq_q;

endmodule
